// File: rtl/link_pkg.sv
// Constants shared by the link master/slave FSMs and the receive buffer.
package link_pkg;

    localparam int unsigned BYTE_W            = 8;
    localparam int unsigned DEFAULT_FRAME_LEN = 4;

endpackage : link_pkg

// File: rtl/link_frame_acc.sv
// Frame tracker: counts pushed bytes into fixed-length frames and reports
// the mod-256 sum of each completed frame with a one-cycle done pulse.
module link_frame_acc
    import link_pkg::*;
#(
    parameter int unsigned FRAME_LEN = DEFAULT_FRAME_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [BYTE_W-1:0] i_data,
    output logic              o_frame_done,
    output logic [BYTE_W-1:0] o_frame_sum
);

    localparam int unsigned IDX_W = 8;

    logic [IDX_W-1:0]  r_byte_idx;
    logic [BYTE_W-1:0] r_acc;
    logic              w_last;

    assign w_last = (r_byte_idx == IDX_W'(FRAME_LEN - 1));

    // Pops never touch this state, so frames may straddle FIFO wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_idx   <= '0;
            r_acc        <= '0;
            o_frame_sum  <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            if (i_push) begin
                if (w_last) begin
                    o_frame_sum  <= r_acc + i_data;
                    o_frame_done <= 1'b1;
                    r_acc        <= '0;
                    r_byte_idx   <= '0;
                end else begin
                    r_acc      <= r_acc + i_data;
                    r_byte_idx <= r_byte_idx + IDX_W'(1);
                end
            end
        end
    end

endmodule : link_frame_acc

// File: rtl/link_rx_buffer.sv
// Receive-side FWFT byte FIFO behind the link slave, with per-frame sum
// reporting and a sticky overflow flag for bytes offered while full.
module link_rx_buffer
    import link_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned FRAME_LEN = DEFAULT_FRAME_LEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [BYTE_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [BYTE_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     frame_done,
    output logic [BYTE_W-1:0]        frame_sum,
    output logic                     err_ovf
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    assign w_full    = (count == (AW+1)'(DEPTH));
    assign w_empty   = (count == '0);
    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            count    <= '0;
            err_ovf  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (in_valid && !in_ready) begin
                err_ovf <= 1'b1;
            end
        end
    end

    link_frame_acc #(
        .FRAME_LEN (FRAME_LEN)
    ) u_frame_acc (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_data       (in_data),
        .o_frame_done (frame_done),
        .o_frame_sum  (frame_sum)
    );

endmodule : link_rx_buffer

// File: tb/tb_link_rx_buffer.sv
// Directed self-checking bench for link_rx_buffer (DEPTH=4, FRAME_LEN=4).
module tb_link_rx_buffer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [2:0] count;
    logic       frame_done;
    logic [7:0] frame_sum;
    logic       err_ovf;

    int n_checks;
    int n_errors;

    link_rx_buffer #(
        .DEPTH     (4),
        .FRAME_LEN (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .count      (count),
        .frame_done (frame_done),
        .frame_sum  (frame_sum),
        .err_ovf    (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        out_ready = 1'b0;
        repeat (cycles) step();
        rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic fill_11_to_44();
        logic [7:0] v [4];
        v = '{8'h11, 8'h22, 8'h33, 8'h44};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(v[i]);
    endtask

    initial begin
        logic [7:0] exp_q [4];
        n_checks = 0;
        n_errors = 0;
        exp_q    = '{8'h11, 8'h22, 8'h33, 8'h44};

        // 1 reset
        do_reset(2);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_count",     32'(count),     32'd0);
        check("rst_frame_sum", 32'(frame_sum), 32'h00);
        check("rst_err_ovf",   32'(err_ovf),   32'd0);
        check("rst_out_data",  32'(out_data),  32'h00);

        // 2 FWFT latency and pop
        push(8'hA5);
        check("fwft_valid", 32'(out_valid), 32'd1);
        check("fwft_data",  32'(out_data),  32'hA5);
        check("fwft_count", 32'(count),     32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("pop_count", 32'(count),     32'd0);
        check("pop_valid", 32'(out_valid), 32'd0);
        check("pop_data",  32'(out_data),  32'h00);

        // 3 fill, back-pressure, order
        do_reset(1);
        fill_11_to_44();
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_count",    32'(count),    32'd4);
        check("full_frame_done", 32'(frame_done), 32'd1);
        check("full_frame_sum",  32'(frame_sum),  32'hAA);
        check("full_head", 32'(out_data), 32'h11);
        // pop while slave offers a byte: pop only, no pass-through
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("bp_in_ready", 32'(in_ready), 32'd1);
        check("bp_count",    32'(count),    32'd3);
        for (int i = 1; i < 4; i++) begin
            check($sformatf("order_%0d", i), 32'(out_data), 32'(exp_q[i]));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        check("drain_count", 32'(count), 32'd0);

        // 4 frame sums: 10+20+30+FF = 15F -> 5F, then 01*4 = 04
        do_reset(1);
        out_ready = 1'b1;
        push(8'h10);
        push(8'h20);
        push(8'h30);
        check("f1_not_done", 32'(frame_done), 32'd0);
        push(8'hFF);
        check("f1_done", 32'(frame_done), 32'd1);
        check("f1_sum",  32'(frame_sum),  32'h5F);
        step();
        check("f1_pulse_end", 32'(frame_done), 32'd0);
        check("f1_sum_held",  32'(frame_sum),  32'h5F);
        for (int i = 0; i < 4; i++) push(8'h01);
        check("f2_done", 32'(frame_done), 32'd1);
        check("f2_sum",  32'(frame_sum),  32'h04);
        out_ready = 1'b0;

        // 5 overflow
        do_reset(1);
        fill_11_to_44();
        push(8'h99);
        check("ovf_flag",  32'(err_ovf),    32'd1);
        check("ovf_count", 32'(count),      32'd4);
        check("ovf_head",  32'(out_data),   32'h11);
        check("ovf_no_frame", 32'(frame_done), 32'd0);
        check("ovf_sum_kept", 32'(frame_sum),  32'hAA);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf_order_%0d", i), 32'(out_data), 32'(exp_q[i]));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        check("ovf_sticky", 32'(err_ovf), 32'd1);
        do_reset(1);
        check("ovf_cleared", 32'(err_ovf), 32'd0);

        // 6 streaming push+pop across pointer wrap; frame 30..33 sums to C6
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(8'(8'h30 + i));
            check($sformatf("strm_data_%0d", i),  32'(out_data), 32'(8'h30 + i));
            check($sformatf("strm_count_%0d", i), 32'(count),    32'd1);
            if (i == 3) check("strm_sum", 32'(frame_sum), 32'hC6);
        end
        out_ready = 1'b0;

        // reset after 2nd byte of a frame: partial frame discarded
        do_reset(1);
        push(8'hF0);
        push(8'hF1);
        do_reset(1);
        check("mid_rst_count", 32'(count), 32'd0);
        push(8'h01);
        push(8'h02);
        push(8'h03);
        check("fresh_not_done", 32'(frame_done), 32'd0);
        push(8'h04);
        check("fresh_done", 32'(frame_done), 32'd1);
        check("fresh_sum",  32'(frame_sum),  32'h0A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_link_rx_buffer
